// File: rtl/lei_pkg.sv
// Shared definitions for the logic engine interface: FSM encoding,
// lei_status bit positions and the default solver timeout.
package lei_pkg;

  typedef enum logic [1:0] {
    LEI_IDLE = 2'd0,
    LEI_REQ  = 2'd1,
    LEI_ACK  = 2'd2
  } lei_state_e;

  localparam int LEI_ST_STATE_LSB    = 0;
  localparam int LEI_ST_LAST_SAT     = 2;
  localparam int LEI_ST_ERROR        = 3;
  localparam int LEI_ST_BUSY         = 4;
  localparam int LEI_ST_CNT_LSB      = 16;

  localparam int LEI_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/logic_engine_interface.sv
// Bridges the CPU four-phase LASSERT handshake to a SAT/SMT solver port,
// with timeout abort, certificate strobe and status/operation counters.
module logic_engine_interface
  import lei_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LEI_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        logic_req,
  input  logic [31:0] logic_addr,
  output logic        logic_ack,
  output logic [31:0] logic_data,
  output logic        z3_req,
  output logic [31:0] z3_formula_addr,
  input  logic        z3_ack,
  input  logic [31:0] z3_result,
  input  logic        z3_sat,
  input  logic [31:0] z3_cert_hash,
  output logic        cert_write,
  output logic [31:0] cert_addr,
  output logic [31:0] cert_data,
  output logic [31:0] lei_status,
  output logic        lei_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

  lei_state_e  r_state, w_state_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt, w_tmo_inc;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic [31:0] r_cert_data, w_cert_data_nxt;
  logic        r_last_sat, w_last_sat_nxt;
  logic        r_error, w_error_nxt;
  logic        r_cert_write, w_cert_write_nxt;
  logic        r_logic_ack, r_z3_req, r_busy;
  logic [31:0] w_status;

  // Next-state and next-output logic; every register defaults to holding.
  always_comb begin
    w_state_nxt      = r_state;
    w_tmo_nxt        = r_tmo;
    w_cnt_nxt        = r_cnt;
    w_addr_nxt       = r_addr;
    w_data_nxt       = r_data;
    w_cert_data_nxt  = r_cert_data;
    w_last_sat_nxt   = r_last_sat;
    w_error_nxt      = r_error;
    w_cert_write_nxt = 1'b0;
    w_tmo_inc        = r_tmo + TW'(1);
    case (r_state)
      LEI_IDLE: begin
        if (logic_req) begin
          w_addr_nxt  = logic_addr;
          w_tmo_nxt   = '0;
          w_state_nxt = LEI_REQ;
        end else begin
          w_state_nxt = LEI_IDLE;
        end
      end
      LEI_REQ: begin
        if (z3_ack) begin
          w_data_nxt       = z3_result;
          w_last_sat_nxt   = z3_sat;
          w_cert_write_nxt = z3_sat;
          w_cert_data_nxt  = z3_sat ? z3_cert_hash : r_cert_data;
          w_cnt_nxt        = r_cnt + 16'd1;
          w_state_nxt      = LEI_ACK;
        end else if (w_tmo_inc >= TMO_LIMIT) begin
          // Solver never answered: return a null result and latch the error.
          w_data_nxt     = 32'd0;
          w_last_sat_nxt = 1'b0;
          w_error_nxt    = 1'b1;
          w_cnt_nxt      = r_cnt + 16'd1;
          w_state_nxt    = LEI_ACK;
        end else begin
          w_tmo_nxt = w_tmo_inc;
        end
      end
      LEI_ACK: begin
        if (!logic_req) begin
          w_state_nxt = LEI_IDLE;
        end else begin
          w_state_nxt = LEI_ACK;
        end
      end
      default: w_state_nxt = LEI_IDLE;
    endcase
  end

  // State, counters and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= LEI_IDLE;
      r_tmo        <= '0;
      r_cnt        <= 16'd0;
      r_addr       <= 32'd0;
      r_data       <= 32'd0;
      r_cert_data  <= 32'd0;
      r_last_sat   <= 1'b0;
      r_error      <= 1'b0;
      r_cert_write <= 1'b0;
      r_logic_ack  <= 1'b0;
      r_z3_req     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tmo        <= w_tmo_nxt;
      r_cnt        <= w_cnt_nxt;
      r_addr       <= w_addr_nxt;
      r_data       <= w_data_nxt;
      r_cert_data  <= w_cert_data_nxt;
      r_last_sat   <= w_last_sat_nxt;
      r_error      <= w_error_nxt;
      r_cert_write <= w_cert_write_nxt;
      r_logic_ack  <= (w_state_nxt == LEI_ACK);
      r_z3_req     <= (w_state_nxt == LEI_REQ);
      r_busy       <= (w_state_nxt != LEI_IDLE);
    end
  end

  // Status word assembled from registers only.
  always_comb begin
    w_status                               = 32'd0;
    w_status[LEI_ST_STATE_LSB +: 2]        = r_state;
    w_status[LEI_ST_LAST_SAT]              = r_last_sat;
    w_status[LEI_ST_ERROR]                 = r_error;
    w_status[LEI_ST_BUSY]                  = r_busy;
    w_status[LEI_ST_CNT_LSB +: 16]         = r_cnt;
  end

  assign logic_ack       = r_logic_ack;
  assign logic_data      = r_data;
  assign z3_req          = r_z3_req;
  assign z3_formula_addr = r_addr;
  assign cert_write      = r_cert_write;
  assign cert_addr       = r_addr;
  assign cert_data       = r_cert_data;
  assign lei_status      = w_status;
  assign lei_error       = r_error;

endmodule

// File: tb/tb_logic_engine_interface.sv
// Self-checking bench: directed spec scenarios plus randomized transactions
// checked against a transaction-level reference model.
module tb_logic_engine_interface;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        logic_req;
  logic [31:0] logic_addr;
  logic        logic_ack;
  logic [31:0] logic_data;
  logic        z3_req;
  logic [31:0] z3_formula_addr;
  logic        z3_ack;
  logic [31:0] z3_result;
  logic        z3_sat;
  logic [31:0] z3_cert_hash;
  logic        cert_write;
  logic [31:0] cert_addr;
  logic [31:0] cert_data;
  logic [31:0] lei_status;
  logic        lei_error;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (transaction level).
  logic [15:0] m_cnt;
  logic        m_err;
  logic        m_sat;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  logic_engine_interface #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .logic_req(logic_req), .logic_addr(logic_addr),
    .logic_ack(logic_ack), .logic_data(logic_data),
    .z3_req(z3_req), .z3_formula_addr(z3_formula_addr),
    .z3_ack(z3_ack), .z3_result(z3_result), .z3_sat(z3_sat),
    .z3_cert_hash(z3_cert_hash),
    .cert_write(cert_write), .cert_addr(cert_addr), .cert_data(cert_data),
    .lei_status(lei_status), .lei_error(lei_error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete four-phase transaction; ack_delay >= TO forces a timeout.
  task automatic do_txn(input logic [31:0] addr, input logic sat, input logic [31:0] res,
                        input logic [31:0] hash, input int ack_delay, input int hold);
    bit timeout;
    bit got;
    int lat;
    int cert_seen;
    int exp_lat;
    logic [31:0] exp_status;
    timeout = (ack_delay >= TO);
    exp_lat = (timeout ? TO : ack_delay + 1) + 1;
    logic_addr = addr; z3_sat = sat; z3_result = res; z3_cert_hash = hash;
    z3_ack = 1'b0; logic_req = 1'b1;
    tick();
    check("req_raised", {63'd0, z3_req}, 64'd1);
    check("formula_addr", {32'd0, z3_formula_addr}, {32'd0, addr});
    logic_addr = $urandom;
    got = 0; lat = 0; cert_seen = 0;
    for (int k = 0; k < 30; k++) begin
      z3_ack = (k >= ack_delay);
      tick();
      if (cert_write) cert_seen++;
      if (logic_ack) begin
        got = 1; lat = k + 2;
        break;
      end
    end
    if (!got) check("ack_never_came", 64'd0, 64'd1);
    z3_ack = 1'($urandom_range(0, 1));
    // Model update from the transaction rules.
    m_cnt  = m_cnt + 16'd1;
    m_data = timeout ? 32'd0 : res;
    m_sat  = timeout ? 1'b0 : sat;
    m_err  = m_err | timeout;
    check("latency", 64'(lat), 64'(exp_lat));
    check("logic_data", {32'd0, logic_data}, {32'd0, m_data});
    check("cert_strobe", 64'(cert_seen), 64'((sat && !timeout) ? 1 : 0));
    if (sat && !timeout) begin
      check("cert_addr", {32'd0, cert_addr}, {32'd0, addr});
      check("cert_data", {32'd0, cert_data}, {32'd0, hash});
    end else begin
      check("z3_req_low", {63'd0, z3_req}, 64'd0);
    end
    exp_status = {m_cnt, 11'd0, 1'b1, m_err, m_sat, 2'd2};
    check("status_ack", {32'd0, lei_status}, {32'd0, exp_status});
    check("lei_error", {63'd0, lei_error}, {63'd0, m_err});
    for (int h = 0; h < hold; h++) begin
      tick();
      if (h == 0) check("cert_one_cycle", {63'd0, cert_write}, 64'd0);
    end
    check("ack_held", {63'd0, logic_ack}, 64'd1);
    logic_req = 1'b0;
    tick();
    check("ack_dropped", {63'd0, logic_ack}, 64'd0);
    check("status_idle", {32'd0, lei_status}, {32'd0, m_cnt, 11'd0, 1'b0, m_err, m_sat, 2'd0});
    check("data_held", {32'd0, logic_data}, {32'd0, m_data});
  endtask

  initial begin
    rst = 1'b1; logic_req = 1'b1; logic_addr = 32'h0000_5555;
    z3_ack = 1'b1; z3_result = 32'd0; z3_sat = 1'b1; z3_cert_hash = 32'd0;
    m_cnt = 16'd0; m_err = 1'b0; m_sat = 1'b0; m_data = 32'd0;
    repeat (3) tick();
    check("reset_outs", {z3_req, logic_ack, cert_write, lei_error, 28'd0, lei_status},
          64'd0);
    check("reset_data", {logic_data, z3_formula_addr}, 64'd0);
    check("reset_cert", {cert_addr, cert_data}, 64'd0);
    rst = 1'b0;

    // Basic SAT with z3_ack tied high.
    do_txn(32'h0000_1234, 1'b1, 32'h0000_1234 ^ 32'hDEAD_BEEF,
           32'h0000_1234 ^ 32'hC0FF_EE00, 0, 1);
    check("sat_data_const", {32'd0, logic_data}, {32'd0, 32'hDEAD_ACDB});
    check("sat_cert_const", {32'd0, cert_data}, {32'd0, 32'hC0FF_FC34});
    check("sat_count", {48'd0, lei_status[31:16]}, 64'd1);

    // UNSAT, held five cycles in ACK.
    do_txn(32'h0000_ABCD, 1'b0, 32'h0000_ABCD ^ 32'hDEAD_BEEF,
           32'h0000_ABCD ^ 32'hC0FF_EE00, 0, 5);
    check("unsat_data_const", {32'd0, logic_data}, {32'd0, 32'hDEAD_1522});
    check("unsat_last_sat", {63'd0, lei_status[2]}, 64'd0);
    check("count_two", {48'd0, lei_status[31:16]}, 64'd2);

    // Timeout, then a good request with the error still sticky.
    do_txn(32'h0000_0042, 1'b1, 32'h1111_2222, 32'h3333_4444, TO + 4, 2);
    check("timeout_err", {63'd0, lei_error}, 64'd1);
    do_txn(32'h0000_0043, 1'b1, 32'h5555_6666, 32'h7777_8888, 3, 1);
    check("err_sticky", {63'd0, lei_error}, 64'd1);

    // Randomized transactions against the model.
    for (int i = 0; i < 20; i++) begin
      do_txn($urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
             $urandom_range(0, TO + 2), $urandom_range(1, 4));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset asserted mid-REQ aborts asynchronously.
    z3_ack = 1'b0; z3_sat = 1'b1; logic_addr = 32'h0000_0777; logic_req = 1'b1;
    tick();
    check("midreq_req", {63'd0, z3_req}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midreq_abort", {61'd0, z3_req, logic_ack, cert_write}, 64'd0);
    check("midreq_status", {32'd0, lei_status}, 64'd0);
    logic_req = 1'b0; z3_ack = 1'b1;
    tick();
    rst = 1'b0;
    m_cnt = 16'd0; m_err = 1'b0; m_sat = 1'b0; m_data = 32'd0;
    check("post_reset_err", {63'd0, lei_error}, 64'd0);
    do_txn(32'h0000_0888, 1'b1, 32'hAAAA_0001, 32'hBBBB_0002, 0, 1);
    check("post_reset_count", {48'd0, lei_status[31:16]}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_engine_interface.md
# logic_engine_interface

Logic Engine Interface (LEI): bridges the Thiele CPU's LASSERT handshake (`logic_req`/`logic_ack`) to an external SAT/SMT solver port (Z3-style request/acknowledge). It forwards the formula address, returns the solver result to the CPU, emits a one-cycle certificate write for satisfiable results, and reports status, error and operation counts. It sits between `thiele_cpu` and the solver or solver mock.

## Interface
- `TIMEOUT_CYCLES`, 1024: cycles to wait in REQ for `z3_ack` before aborting; minimum 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `logic_req` in 1: CPU request, four-phase.
- `logic_addr` in 32: formula address from the CPU. LASSERT drives `{16'h0, op_a, op_b}`.
- `logic_ack` out 1: completion to the CPU.
- `logic_data` out 32: solver result returned to the CPU.
- `z3_req` out 1: solver request.
- `z3_formula_addr` out 32: latched formula address.
- `z3_ack` in 1: solver done; may be tied high.
- `z3_result` in 32: solver result word.
- `z3_sat` in 1: 1 means SAT.
- `z3_cert_hash` in 32: certificate hash.
- `cert_write` out 1: one-cycle certificate store strobe.
- `cert_addr` out 32: certificate address, equal to the latched formula address.
- `cert_data` out 32: certificate hash.
- `lei_status` out 32: [1:0] state, [2] last_sat, [3] error, [4] busy, [15:5] zero, [31:16] completed-operation count.
- `lei_error` out 1: sticky timeout flag.

## Operation
- FSM states: IDLE=0, REQ=1, ACK=2.
- **IDLE**
  - `logic_ack`=0 and `z3_req`=0.
  - When `logic_req`=1 is sampled: latch `logic_addr` into `z3_formula_addr`, clear the timeout counter, go to REQ.
- **REQ**
  - `z3_req`=1.
  - When `z3_ack`=1 is sampled:
    - Register `logic_data`←`z3_result`.
    - Register `last_sat`←`z3_sat`.
    - If `z3_sat`=1: assert `cert_write`=1 for one cycle, with `cert_addr`=`z3_formula_addr` and `cert_data`=`z3_cert_hash`.
    - Increment the operation count, which wraps at 16 bits.
    - Go to ACK.
  - Timeout: the counter reaches TIMEOUT_CYCLES without `z3_ack`. Then `logic_data`←0, `last_sat`←0, `lei_error`←1, no `cert_write`, the count still increments, go to ACK.
- **ACK**
  - `z3_req`=0 and `logic_ack`=1.
  - Stay in ACK while `logic_req`=1. When `logic_req`=0 is sampled, go to IDLE.
- `logic_addr` changes after latching are ignored.
- `z3_ack` is ignored outside REQ.
- `logic_data` holds its value until the next completion.
- `lei_error` clears only on `rst`.
- A new request is accepted in IDLE even if `lei_error`=1.
- If `logic_req` drops while in REQ, the transaction still completes and ACK exits on the next cycle in which `logic_req`=0 is sampled.

## Timing
- Reset values: all outputs 0. State IDLE, counters 0, `last_sat`=0.
- `rst` asserted mid-transaction aborts immediately: `z3_req`, `logic_ack` and `cert_write` go to 0 asynchronously.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency with `z3_ack` tied high:
  - Edge N samples `logic_req`; `z3_req`=1 after N.
  - Edge N+1 samples `z3_ack`; `logic_ack`, `logic_data` and `cert_write` are valid after N+1.
  - The request-to-acknowledge latency is therefore 2 cycles.
- `cert_write` is high for exactly the one cycle after the completing edge.
- `z3_formula_addr` stays stable from REQ entry until the next accepted request.
- Timeout fires on the edge where the REQ-cycle count equals TIMEOUT_CYCLES.

## Structure
- Shared package `lei_pkg`:
  - State encoding constants `LEI_IDLE`, `LEI_REQ`, `LEI_ACK`.
  - `lei_status` bit-position constants.
  - Default TIMEOUT_CYCLES.
- Single flat module; no sub-module. The timeout counter and operation counter are inline registers.

## Test plan
- Reset: hold `rst`=1 with `logic_req`=1 → all outputs 0 and state IDLE; after release, a request proceeds normally.
- Basic SAT: tie `z3_ack`=1, `z3_result`=addr^32'hDEADBEEF, `z3_cert_hash`=addr^32'hC0FFEE00, `z3_sat`=1; `logic_addr`=32'h00001234. Required response:
  - `logic_ack` 2 cycles after `logic_req`.
  - `logic_data`=32'hDEADACDB.
  - One-cycle `cert_write` with `cert_addr`=32'h00001234, `cert_data`=32'hC0FFFC34.
  - `lei_status`[31:16]=1.
- UNSAT: same setup with `z3_sat`=0, `logic_addr`=32'h0000ABCD → `logic_data`=32'hDEAD1522, no `cert_write`, `lei_status`[2]=0.
- Four-phase: hold `logic_req` for 5 cycles after ack → `logic_ack` stays 1. Drop `logic_req` → `logic_ack`=0 next cycle, state IDLE. Second request → count=2.
- Timeout: TIMEOUT_CYCLES=8, `z3_ack`=0 → `logic_ack` after 8 REQ cycles, `logic_data`=0, `lei_error`=1 and sticky. A subsequent good request succeeds while `lei_error` stays 1.
- Reset mid-REQ: assert `rst` while `z3_req`=1 → `z3_req`=0 immediately, no `cert_write`, count=0.
